tile_engine: RTL and testbench
==============================

TILE_ENGINE -- requirements
Module: tile_engine

Interface
REQ-001 SHALL have parameter MAP_COLS, default 40, tile columns in map.
REQ-002 SHALL have parameter MAP_ROWS, default 30, tile rows in map.
REQ-003 SHALL have parameter NUM_TILES, default 64, tile definitions (8x8, 1 bpp, 64-bit each).
REQ-004 SHALL have parameter PAL_ENTRIES, default 16, 12-bit RGB444 palette entries.
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports x, y  in  12 each  pixel coordinate from timing generator.
REQ-008 SHALL have port pix_in  in  1  x/y valid (active area).
REQ-009 SHALL have ports r, g, b  out  8 each  pixel colour, {4-bit channel, 4'b0000}.
REQ-010 SHALL have port pix_out  out  1  r/g/b valid, pix_in delayed 3 cycles.
REQ-011 SHALL have ports vblank  in  1, scroll_x  in  12, scroll_y  in  12  frame marker and pixel scroll offsets.
REQ-012 SHALL have ports wr_en  in  1, wr_sel  in  2 (0 palette, 1 tiledef, 2 tilemap, 3 attrmap), wr_addr  in  11, wr_data  in  64, wr_ready  out  1.
REQ-013 SHALL have port clear_req  in  1  pulse requesting full memory clear.

Function
REQ-014 SHALL render a 3-stage pipeline: S1 map index, S2 tile bit, S3 palette lookup; latency exactly 3 cycles from x/y to r/g/b.
REQ-015 SHALL compute effective coords ex=(x+sx) mod (MAP_COLS*8), ey=(y+sy) mod (MAP_ROWS*8), where sx/sy are latched scroll values.
REQ-016 SHALL use map index m=(ey>>3)*MAP_COLS+(ex>>3), tile t=tilemap[m] (width clog2(NUM_TILES)), bit tiledef[t][(ey&7)*8+(ex&7)].
REQ-017 SHALL select palette index attrmap[m][7:4] when bit=1, attrmap[m][3:0] when bit=0; colour = palette[index].
REQ-018 SHALL output r=g=b=0 when pix_out=0, when x>=MAP_COLS*8 or y>=MAP_ROWS*8 (pre-scroll), or while state is CLEAR.
REQ-019 SHALL latch scroll_x/scroll_y into sx/sy only on the cycle vblank rises (0->1); mid-frame scroll changes SHALL NOT affect the current frame.
REQ-020 SHALL accept a write on any cycle with wr_en=1 and wr_ready=1; data visible to reads from the following cycle; same-cycle read returns old data.
REQ-021 SHALL use wr_data[11:0] for palette, [63:0] tiledef, [5:0] tilemap, [7:0] attrmap; wr_addr beyond the selected memory depth SHALL be ignored with no side effect.
REQ-022 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR on clear_req=1; CLEAR walks counter 0..MAP_COLS*MAP_ROWS-1 writing 0 to every entry of all four memories (index beyond a memory's depth skipped); CLEAR->IDLE after last index.
REQ-023 SHALL hold wr_ready=0 in CLEAR, 1 in IDLE; clear_req during CLEAR SHALL restart the counter at 0.
REQ-024 SHALL give clear priority over a simultaneous wr_en on the clear_req cycle (write dropped since wr_ready falls that cycle only if already in CLEAR; in IDLE the write in that cycle completes first, then clear).

Reset
REQ-025 SHALL on resetn=0 immediately force: state=CLEAR, counter=0, sx=sy=0, pipeline valids=0, pix_out=0, r=g=b=0, wr_ready=0.
REQ-026 SHALL after resetn release run a full CLEAR pass (MAP_COLS*MAP_ROWS cycles) before wr_ready=1; reset asserted mid-CLEAR SHALL restart from 0.

Configuration
REQ-027 SHALL with macro TILE_ENGINE_SCROLL_EN defined implement REQ-015 and REQ-019 scroll behaviour.
REQ-028 SHALL without TILE_ENGINE_SCROLL_EN hold sx=sy=0 (no scroll registers), ignoring scroll_x, scroll_y and vblank; all other behaviour unchanged.

Verification
REQ-029 SHALL check reset: resetn low then high -> wr_ready=0 for exactly 1200 cycles (default params), then 1; r/g/b=0 throughout.
REQ-030 SHALL check render: palette[3]=12'hF80, palette[1]=12'h00F, tiledef[5]=64'h1, tilemap[0]=5, attrmap[0]=8'h31, pix_in=1, x=y=0 -> 3 cycles later r=8'hF0,g=8'h80,b=0; x=1,y=0 -> r=g=0,b=8'hF0.
REQ-031 SHALL check bounds: x=320,y=0,pix_in=1 -> r=g=b=0 after 3 cycles, pix_out=1.
REQ-032 SHALL check scroll (macro on): scroll_x=8 before vblank rise, x=0 -> pixel from map column 1; scroll_x=312 -> x=8 wraps to column 0; change scroll_x mid-frame -> output unchanged until next vblank rise.
REQ-033 SHALL check clear: clear_req with wr_en same cycle in IDLE -> write lands then is cleared to 0; wr_ready low 1200 cycles; second clear_req at cycle 600 -> 1200 further cycles.
REQ-034 SHALL check write to wr_sel=1, wr_addr=64 -> ignored; tiledef[0..63] unchanged.

Source files
------------

// File: rtl/tile_engine.sv
// Tile-map renderer: 8x8 1bpp tiles, per-cell attribute palette pair, RGB444 palette, 3-cycle pixel pipeline.
// Optional scrolling is enabled by defining TILE_ENGINE_SCROLL_EN; otherwise the view is fixed at the map origin.
//
// state  | meaning
// IDLE   | memories writable, rendering active
// CLEAR  | walking the clear counter, zeroing all memories, writes blocked, output forced black
module tile_engine #(
  parameter int MAP_COLS    = 40,
  parameter int MAP_ROWS    = 30,
  parameter int NUM_TILES   = 64,
  parameter int PAL_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        pix_in,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        pix_out,
  input  logic        vblank,
  input  logic [11:0] scroll_x,
  input  logic [11:0] scroll_y,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [10:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  input  logic        clear_req
);

  localparam int MAP_W  = MAP_COLS * 8;
  localparam int MAP_H  = MAP_ROWS * 8;
  localparam int MAP_N  = MAP_COLS * MAP_ROWS;
  localparam int MIDX_W = $clog2(MAP_N);
  localparam int T_W    = $clog2(NUM_TILES);
  localparam int PAL_AW = $clog2(PAL_ENTRIES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [11:0]      palette [PAL_ENTRIES];
  logic [63:0]      tiledef [NUM_TILES];
  logic [T_W-1:0]   tilemap [MAP_N];
  logic [7:0]       attrmap [MAP_N];

  logic [0:0]        state;
  logic [MIDX_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (clear_req) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == MIDX_W'(MAP_N - 1)) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign wr_ready = (state == ST_IDLE);

  // One memory port per array: the clear walk owns it while clearing, the host otherwise.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      if (int'(clr_cnt) < PAL_ENTRIES) palette[clr_cnt[PAL_AW-1:0]] <= '0;
      if (int'(clr_cnt) < NUM_TILES)   tiledef[clr_cnt[T_W-1:0]]    <= '0;
      tilemap[clr_cnt] <= '0;
      attrmap[clr_cnt] <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0: if (int'(wr_addr) < PAL_ENTRIES) palette[wr_addr[PAL_AW-1:0]] <= wr_data[11:0];
        2'd1: if (int'(wr_addr) < NUM_TILES)   tiledef[wr_addr[T_W-1:0]]    <= wr_data;
        2'd2: if (int'(wr_addr) < MAP_N)       tilemap[wr_addr[MIDX_W-1:0]] <= wr_data[T_W-1:0];
        default: if (int'(wr_addr) < MAP_N)    attrmap[wr_addr[MIDX_W-1:0]] <= wr_data[7:0];
      endcase
    end
  end

  logic [11:0] sx;
  logic [11:0] sy;

`ifdef TILE_ENGINE_SCROLL_EN
  logic vblank_q;

  // Scroll only moves at the start of vertical blank so a frame never tears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vblank_q <= 1'b0;
      sx       <= '0;
      sy       <= '0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q) begin
        sx <= scroll_x;
        sy <= scroll_y;
      end
    end
  end
`else
  logic unused_scroll;
  assign sx = '0;
  assign sy = '0;
  assign unused_scroll = ^{vblank, scroll_x, scroll_y};
`endif

  logic [12:0]       sum_x, sum_y, ex, ey;
  logic [MIDX_W-1:0] m;
  logic              inb;

  assign sum_x = {1'b0, x} + {1'b0, sx};
  assign sum_y = {1'b0, y} + {1'b0, sy};
  assign ex    = sum_x % 13'(MAP_W);
  assign ey    = sum_y % 13'(MAP_H);
  assign m     = MIDX_W'(ey[12:3]) * MIDX_W'(MAP_COLS) + MIDX_W'(ex[12:3]);
  // Bounds use the unscrolled coordinate: the visible window is fixed, only its content moves.
  assign inb   = (x < 12'(MAP_W)) && (y < 12'(MAP_H));

  logic              v1, inb1;
  logic [MIDX_W-1:0] m1;
  logic [5:0]        bit1;
  logic              v2, inb2;
  logic [3:0]        pidx2;

  logic [T_W-1:0] t_s2;
  logic [7:0]     attr_s2;
  logic [63:0]    tdef_s2;
  logic [11:0]    col_s3;

  assign t_s2    = tilemap[m1];
  assign attr_s2 = attrmap[m1];
  assign tdef_s2 = (int'(t_s2) < NUM_TILES) ? tiledef[t_s2] : '0;
  assign col_s3  = (int'(pidx2) < PAL_ENTRIES) ? palette[pidx2[PAL_AW-1:0]] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1      <= 1'b0;
      inb1    <= 1'b0;
      m1      <= '0;
      bit1    <= '0;
      v2      <= 1'b0;
      inb2    <= 1'b0;
      pidx2   <= '0;
      pix_out <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      v1      <= pix_in;
      inb1    <= inb;
      m1      <= m;
      bit1    <= {ey[2:0], ex[2:0]};
      v2      <= v1;
      inb2    <= inb1;
      pidx2   <= tdef_s2[bit1] ? attr_s2[7:4] : attr_s2[3:0];
      pix_out <= v2;
      if (v2 && inb2 && (state == ST_IDLE)) begin
        r <= {col_s3[11:8], 4'b0000};
        g <= {col_s3[7:4],  4'b0000};
        b <= {col_s3[3:0],  4'b0000};
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_engine.sv
// Self-checking bench for tile_engine: random scenes checked against a coordinate-arithmetic reference model.
module tb_tile_engine;

  localparam int COLS = 40;
  localparam int MW   = 320;
  localparam int MH   = 240;
  localparam int MN   = 1200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] x = '0, y = '0;
  logic        pix_in = 1'b0;
  logic [7:0]  r, g, b;
  logic        pix_out;
  logic        vblank = 1'b0;
  logic [11:0] scroll_x = '0, scroll_y = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [10:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_ready;
  logic        clear_req = 1'b0;

  always #5 clk = ~clk;

  tile_engine dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .pix_in(pix_in),
    .r(r), .g(g), .b(b), .pix_out(pix_out),
    .vblank(vblank), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear_req(clear_req)
  );

  int errors = 0;
  int checks = 0;

  logic [11:0] m_pal  [16];
  logic [63:0] m_tdef [64];
  logic [5:0]  m_tmap [MN];
  logic [7:0]  m_attr [MN];
  int          m_sx = 0, m_sy = 0;

  int          st_x [512];
  int          st_y [512];
  bit          st_v [512];
  logic [24:0] st_exp [512];
  logic [24:0] st_obs [512];

  function automatic void model_zero();
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    for (int i = 0; i < 64; i++) m_tdef[i] = '0;
    for (int i = 0; i < MN; i++) begin m_tmap[i] = '0; m_attr[i] = '0; end
  endfunction

  function automatic logic [24:0] ref_out(input int xx, input int yy, input bit v);
    int ex, ey, mi, t, bi, idx;
    logic [11:0] c;
    if (!v) return 25'h0;
    if (xx >= MW || yy >= MH) return {1'b1, 24'h0};
    ex  = (xx + m_sx) % MW;
    ey  = (yy + m_sy) % MH;
    mi  = (ey / 8) * COLS + ex / 8;
    t   = m_tmap[mi];
    bi  = (ey % 8) * 8 + (ex % 8);
    idx = m_tdef[t][bi] ? int'(m_attr[mi][7:4]) : int'(m_attr[mi][3:0]);
    c   = m_pal[idx];
    return {1'b1, c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0};
  endfunction

  task automatic wr(input logic [1:0] sel, input int addr, input logic [63:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 11'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    case (sel)
      2'd0: if (addr < 16) m_pal[addr]  = data[11:0];
      2'd1: if (addr < 64) m_tdef[addr] = data;
      2'd2: if (addr < MN) m_tmap[addr] = data[5:0];
      default: if (addr < MN) m_attr[addr] = data[7:0];
    endcase
  endtask

  task automatic fill(input int n, input int xlo, input int xhi, input int ylo, input int yhi);
    for (int i = 0; i < n; i++) begin
      st_x[i] = $urandom_range(xhi, xlo);
      st_y[i] = $urandom_range(yhi, ylo);
      st_v[i] = ($urandom_range(3, 0) != 0);
    end
  endtask

  task automatic stream(input int n, input string tag);
    int j;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        x = 12'(st_x[i]); y = 12'(st_y[i]); pix_in = st_v[i];
        st_exp[i] = ref_out(st_x[i], st_y[i], st_v[i]);
      end else begin
        pix_in = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        j = i - 2;
        st_obs[j] = {pix_out, r, g, b};
        checks++;
        if (st_obs[j] !== st_exp[j]) begin
          errors++;
          $display("FAIL %s[%0d] x=%0d y=%0d: got %h expected %h", tag, j, st_x[j], st_y[j], st_obs[j], st_exp[j]);
        end
      end
    end
  endtask

  task automatic count_clear(output int cnt, output int bad);
    cnt = 0; bad = 0;
    while (wr_ready !== 1'b1 && cnt < 1300) begin
      x = 12'($urandom_range(MW - 1, 0));
      @(negedge clk);
      cnt++;
      if ({r, g, b} !== 24'h0) bad++;
    end
  endtask

  task automatic test_reset();
    int cnt, bad;
    pix_in = 1'b1; x = 0; y = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_ready, pix_out, r, g, b} !== 26'h0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", {wr_ready, pix_out, r, g, b});
    end
    resetn = 1'b1;
    repeat (500) @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_partial: wr_ready=%b expected 0", wr_ready); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({wr_ready, pix_out, r, g, b} !== 26'h0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", {wr_ready, pix_out, r, g, b});
    end
    @(negedge clk);
    resetn = 1'b1;
    count_clear(cnt, bad);
    checks++;
    if (cnt !== 1200) begin errors++; $display("FAIL reset_clear_len: got %0d expected 1200", cnt); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_rgb_zero: %0d nonzero cycles expected 0", bad); end
    pix_in = 1'b0;
    repeat (4) @(negedge clk);
    model_zero();
  endtask

  task automatic test_render_spec();
    logic [24:0] want [4];
    want[0] = {1'b1, 24'hF08000};
    want[1] = {1'b1, 24'h0000F0};
    want[2] = {1'b1, 24'h000000};
    want[3] = 25'h0;
    wr(2'd0, 3, 64'hF80);
    wr(2'd0, 1, 64'h00F);
    wr(2'd1, 5, 64'h1);
    wr(2'd2, 0, 64'd5);
    wr(2'd3, 0, 64'h31);
    st_x[0] = 0;   st_y[0] = 0; st_v[0] = 1'b1;
    st_x[1] = 1;   st_y[1] = 0; st_v[1] = 1'b1;
    st_x[2] = 320; st_y[2] = 0; st_v[2] = 1'b1;
    st_x[3] = 2;   st_y[3] = 0; st_v[3] = 1'b0;
    stream(4, "render_model");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st_obs[i] !== want[i]) begin
        errors++; $display("FAIL render_const[%0d]: got %h expected %h", i, st_obs[i], want[i]);
      end
    end
  endtask

  task automatic test_rw_timing();
    wr(2'd1, 10, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'd1, 11, 64'h0);
    wr(2'd3, 0, 64'h21);
    wr(2'd0, 2, 64'h123);
    wr(2'd0, 1, 64'h456);
    wr(2'd2, 0, 64'd10);
    // write and pixel in the same cycle: the pixel must see the new tile
    wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 0; wr_data = 64'd11;
    x = 0; y = 0; pix_in = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; pix_in = 1'b0; m_tmap[0] = 6'd11;
    repeat (2) @(negedge clk);
    checks++;
    if ({pix_out, r, g, b} !== {1'b1, 24'h405060}) begin
      errors++; $display("FAIL rw_new: got %h expected %h", {pix_out, r, g, b}, {1'b1, 24'h405060});
    end
    repeat (2) @(negedge clk);
    // write one cycle after the pixel: tile fetch coincides with the write, so old data
    x = 0; y = 0; pix_in = 1'b1;
    @(negedge clk);
    pix_in = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 0; wr_data = 64'd10;
    @(negedge clk);
    wr_en = 1'b0; m_tmap[0] = 6'd10;
    @(negedge clk);
    checks++;
    if ({pix_out, r, g, b} !== {1'b1, 24'h405060}) begin
      errors++; $display("FAIL rw_old: got %h expected %h", {pix_out, r, g, b}, {1'b1, 24'h405060});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bounds_write();
    logic [63:0] pat;
    pat = {$urandom, $urandom};
    wr(2'd0, 0, 64'h0F0);
    wr(2'd1, 0, pat);
    wr(2'd2, 0, 64'd0);
    wr(2'd2, 1, 64'd0);
    wr(2'd3, 0, 64'h21);
    wr(2'd3, 1, 64'h00);
    wr(2'd1, 64, ~pat);
    wr(2'd0, 16, 64'hFFF);
    wr(2'd3, 1200, 64'hFF);
    for (int i = 0; i < 64; i++) begin st_x[i] = i % 8; st_y[i] = i / 8; st_v[i] = 1'b1; end
    for (int i = 64; i < 72; i++) begin st_x[i] = i - 56; st_y[i] = 0; st_v[i] = 1'b1; end
    stream(72, "bounds_write");
  endtask

  task automatic test_random_render();
    for (int i = 0; i < 16; i++) wr(2'd0, i, 64'($urandom_range(4095, 0)));
    for (int i = 0; i < 64; i++) wr(2'd1, i, {$urandom, $urandom});
    for (int i = 0; i < 80; i++) begin
      wr(2'd2, i, 64'($urandom_range(63, 0)));
      wr(2'd3, i, 64'($urandom_range(255, 0)));
    end
    fill(200, 0, 335, 0, 17);
    stream(200, "random_rows");
    fill(60, 0, 340, 0, 250);
    stream(60, "random_map");
  endtask

  task automatic vblank_pulse(input int sxv, input int syv);
    scroll_x = 12'(sxv); scroll_y = 12'(syv); vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
`ifdef TILE_ENGINE_SCROLL_EN
    m_sx = sxv; m_sy = syv;
`endif
  endtask

  task automatic test_scroll();
    vblank_pulse(8, 0);
    st_x[0] = 0; st_y[0] = 0; st_v[0] = 1'b1;
    fill(40, 0, 23, 0, 17);
    st_x[1] = 0; st_y[1] = 3; st_v[1] = 1'b1;
    stream(40, "scroll_8");
    vblank_pulse(312, 0);
    st_x[0] = 8; st_y[0] = 0; st_v[0] = 1'b1;
    fill(40, 0, 23, 0, 17);
    st_x[0] = 8; st_y[0] = 0; st_v[0] = 1'b1;
    stream(40, "scroll_wrap");
    scroll_x = 12'd100; scroll_y = 12'd230;
    repeat (2) @(negedge clk);
    fill(40, 0, 40, 0, 17);
    stream(40, "scroll_midframe");
    vblank_pulse(100, 230);
    fill(40, 0, 40, 0, 17);
    stream(40, "scroll_next_frame");
  endtask

  task automatic test_clear();
    int cnt, bad;
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 5; wr_data = 64'hFFF;
    clear_req = 1'b1; pix_in = 1'b1; x = 0; y = 0;
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_enter: wr_ready=%b expected 0", wr_ready); end
    cnt = 0; bad = 0;
    while (wr_ready !== 1'b1 && cnt < 1300) begin
      wr_en = (cnt == 1190); wr_sel = 2'd0; wr_addr = 7; wr_data = 64'hFFF;
      @(negedge clk);
      cnt++;
      if ({r, g, b} !== 24'h0) bad++;
    end
    wr_en = 1'b0;
    checks++;
    if (cnt !== 1200) begin errors++; $display("FAIL clear_len: got %0d expected 1200", cnt); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clear_rgb_zero: %0d nonzero cycles expected 0", bad); end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (599) @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_mid: wr_ready=%b expected 0", wr_ready); end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    count_clear(cnt, bad);
    checks++;
    if (cnt !== 1200) begin errors++; $display("FAIL clear_restart_len: got %0d expected 1200", cnt); end
    pix_in = 1'b0;
    repeat (3) @(negedge clk);
    model_zero();
    wr(2'd3, 0, 64'h55);
    wr(2'd3, 1, 64'h77);
    fill(16, 0, 15, 0, 7);
    stream(16, "clear_zero");
    wr(2'd0, 0, 64'h9A5);
    fill(60, 0, 330, 0, 245);
    stream(60, "clear_after");
  endtask

  initial begin
    test_reset();
    test_render_spec();
    test_rw_timing();
    test_bounds_write();
    test_random_render();
    test_scroll();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
